// File: rtl/maxpool_channel_scheduler_if.sv
// Control/engine handshake bundle for the max-pool channel scheduler.
// The scheduler takes the slave view. The sequencer/engine side takes the master view.
interface maxpool_channel_scheduler_if #(
  parameter int CHANNEL_COUNT = 2,
  parameter int CH_W          = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
);
  logic                     start;
  logic [CHANNEL_COUNT-1:0] ch_mask;
  logic                     abort;
  logic                     eng_start;
  logic                     eng_done;
  logic [CH_W-1:0]          ch_sel;
  logic                     cap_en;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [CHANNEL_COUNT-1:0] done_mask;

  modport master (
    output start, ch_mask, abort, eng_done,
    input  eng_start, ch_sel, cap_en, busy, done, error, done_mask
  );

  modport slave (
    input  start, ch_mask, abort, eng_done,
    output eng_start, ch_sel, cap_en, busy, done, error, done_mask
  );
endinterface

// File: rtl/maxpool_channel_scheduler.sv
// Shares one single-channel max-pool engine across CHANNEL_COUNT channels.
// The pass walks the enabled channels in ascending order: launch, wait for done, then capture.
module maxpool_channel_scheduler #(
  parameter int CHANNEL_COUNT  = 2,
  parameter int CH_W           = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  maxpool_channel_scheduler_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    LAUNCH  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    FINISH  = 3'd5
  } state_t;

  localparam logic [CH_W-1:0] IDX_LAST = CH_W'(CHANNEL_COUNT - 1);
  localparam int              TMO_M1   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_M1);

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          idx;
  logic [TMR_W-1:0]         timer;
  logic [CHANNEL_COUNT-1:0] mask_q;
  logic [CHANNEL_COUNT-1:0] done_mask_q;
  logic                     error_q;

  logic is_last;
  logic timeout_hit;

  assign is_last     = (idx == IDX_LAST);
  // The timer reads N-1 during the N-th WAIT cycle, because it is cleared in LAUNCH.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_LAST);

  // NOTE: the async reset is in the sensitivity list. All state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every comb block assigns a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN: begin
        if (mask_q[idx])  state_nxt = LAUNCH;
        else if (is_last) state_nxt = FINISH;
      end
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (bus.eng_done)     state_nxt = CAPTURE;
        else if (timeout_hit) state_nxt = FINISH;
      end
      CAPTURE: state_nxt = is_last ? FINISH : SCAN;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_comb begin
    bus.eng_start = 1'b0;
    bus.cap_en    = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE);
    unique case (state)
      LAUNCH:  bus.eng_start = 1'b1;
      CAPTURE: bus.cap_en    = 1'b1;
      FINISH:  bus.done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      timer       <= '0;
      mask_q      <= '0;
      done_mask_q <= '0;
      error_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          mask_q      <= bus.ch_mask;
          done_mask_q <= '0;
          error_q     <= 1'b0;
          idx         <= '0;
        end
        SCAN:    if (!bus.abort && !mask_q[idx] && !is_last) idx <= idx + 1'b1;
        LAUNCH:  timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (!bus.abort && !bus.eng_done && timeout_hit) error_q <= 1'b1;
        end
        CAPTURE: begin
          // The strobe has already gone out this cycle, so the capture is recorded even under abort.
          done_mask_q[idx] <= 1'b1;
          if (!bus.abort && !is_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ch_sel    = idx;
  assign bus.error     = error_q;
  assign bus.done_mask = done_mask_q;

endmodule

// File: tb/tb_maxpool_channel_scheduler.sv
// Directed bench for maxpool_channel_scheduler (2 channels, 8-cycle timeout).
// A small engine model answers eng_start after a programmable latency.
module tb_maxpool_channel_scheduler;

  logic clk;
  logic rst;

  maxpool_channel_scheduler_if #(.CHANNEL_COUNT(2)) bus ();

  maxpool_channel_scheduler #(
    .CHANNEL_COUNT (2),
    .TIMEOUT_CYCLES(8),
    .TMR_W         (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The engine model raises eng_done for one cycle, eng_lat cycles after it sees eng_start.
  int   eng_lat  = 5;
  int   eng_cnt  = 0;
  logic eng_auto = 1'b1;
  logic eng_fire = 1'b0;
  logic eng_spur = 1'b0;

  assign bus.eng_done = (eng_auto & eng_fire) | eng_spur;

  always begin
    @(posedge clk);
    #1;
    eng_fire = 1'b0;
    if (!rst) eng_cnt = 0;
    else if (bus.eng_start) eng_cnt = eng_lat;
    else if (eng_cnt != 0) begin
      eng_cnt  = eng_cnt - 1;
      eng_fire = (eng_cnt == 0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns in cycle T1, which is the first cycle after start was accepted.
  task automatic start_pass(input logic [1:0] mask);
    bus.ch_mask = mask;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  function automatic logic [4:0] outs();
    return {bus.busy, bus.eng_start, bus.cap_en, bus.done, bus.error};
  endfunction

  initial begin
    int ce;
    int es;
    int dn;
    int act;

    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.ch_mask = 2'b00;
    bus.abort   = 1'b0;
    step(2);
    check("reset_outs",      outs(),        5'b0);
    check("reset_ch_sel",    bus.ch_sel,    1'b0);
    check("reset_done_mask", bus.done_mask, 2'b00);
    rst = 1'b1;
    step();

    // Mask 11 with a 5-cycle engine. The ch_mask change mid-pass must have no effect.
    start_pass(2'b11);
    for (int t = 1; t <= 17; t++) begin
      check($sformatf("passA_ctl_T%0d", t),
            {bus.busy, bus.eng_start, bus.cap_en, bus.done},
            {1'b1, (t == 2 || t == 10), (t == 8 || t == 16), (t == 17)});
      check($sformatf("passA_sel_T%0d", t), bus.ch_sel, (t >= 9));
      if (t == 3) bus.ch_mask = 2'b00;
      if (t < 17) step();
    end
    check("passA_done_mask", bus.done_mask, 2'b11);
    check("passA_error",     bus.error,     1'b0);
    step();
    check("passA_idle", bus.busy, 1'b0);

    // Mask 10: ch0 is skipped and the launch comes at T3 on channel 1.
    start_pass(2'b10);
    ce = 0;
    for (int t = 1; t <= 10; t++) begin
      if (bus.cap_en) ce++;
      if (t == 2)  check("passB_no_launch_T2", bus.eng_start, 1'b0);
      if (t == 3)  check("passB_launch_T3", {bus.eng_start, bus.ch_sel}, 2'b11);
      if (t == 10) check("passB_done_T10", {bus.done, bus.done_mask}, 3'b110);
      if (t < 10) step();
    end
    check("passB_cap_count", ce, 1);
    step();

    // Timeout: the engine stays silent, WAIT runs T3..T10, and done comes at T11 with error set.
    eng_auto = 1'b0;
    start_pass(2'b01);
    step();
    check("tmo_launch_T2", bus.eng_start, 1'b1);
    step(8);
    check("tmo_T10", outs(), 5'b10000);
    step();
    check("tmo_T11", outs(), 5'b10011);
    check("tmo_done_mask", bus.done_mask, 2'b00);
    step();
    check("tmo_sticky", outs(), 5'b00001);
    eng_auto = 1'b1;

    // Empty mask: the next start clears error, and done comes CHANNEL_COUNT+1 cycles later.
    start_pass(2'b00);
    check("empty_T1", outs(), 5'b10000);
    step();
    check("empty_T2", bus.done, 1'b0);
    step();
    check("empty_T3", {bus.done, bus.done_mask}, 3'b100);
    step();

    // eng_done on the 8th WAIT cycle wins over the timeout.
    eng_lat = 8;
    start_pass(2'b01);
    step(10);
    check("tie_capture_T11", {bus.cap_en, bus.error}, 2'b10);
    step(2);
    check("tie_finish_T13", {bus.done, bus.error, bus.done_mask}, 4'b1001);
    step();
    eng_lat = 5;

    // Abort during ch1 WAIT (T12). The late eng_done at T15 lands in IDLE and is ignored.
    start_pass(2'b11);
    step(11);
    check("abort_in_wait", {bus.busy, bus.eng_start, bus.ch_sel}, 3'b101);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle", {bus.busy, bus.done, bus.done_mask}, 4'b0001);
    act = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (bus.busy || bus.eng_start || bus.cap_en || bus.done) act++;
    end
    check("abort_quiet", act, 0);
    check("abort_partial", bus.done_mask, 2'b01);

    // start together with abort in IDLE is accepted. The full pass then completes normally.
    bus.abort = 1'b1;
    start_pass(2'b11);
    bus.abort = 1'b0;
    check("abort_start_T1", bus.busy, 1'b1);
    step(16);
    check("rerun_T17", {bus.done, bus.error, bus.done_mask}, 4'b1011);
    step();

    // A spurious eng_done in IDLE has no effect.
    eng_spur = 1'b1;
    step();
    eng_spur = 1'b0;
    check("spur_idle", outs(), 5'b0);
    step();
    check("spur_after", outs(), 5'b0);

    // start held for 20 sampling edges with a 7-cycle engine: only one pass runs (done at T21).
    eng_lat     = 7;
    bus.ch_mask = 2'b11;
    bus.start   = 1'b1;
    es = 0;
    dn = 0;
    for (int t = 1; t <= 22; t++) begin
      step();
      if (t == 20) bus.start = 1'b0;
      if (bus.eng_start) es++;
      if (bus.done) begin
        dn++;
        check("held_done_time", t, 21);
      end
    end
    check("held_launches", es, 2);
    check("held_dones", dn, 1);
    check("held_idle", bus.busy, 1'b0);
    step();
    check("held_stays_idle", bus.busy, 1'b0);
    eng_lat = 5;

    // Asynchronous reset in the middle of ch1 WAIT.
    start_pass(2'b11);
    step(11);
    check("pre_rst_state", {bus.busy, bus.ch_sel, bus.done_mask}, 4'b1101);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_outs", outs(), 5'b0);
    check("async_rst_sel_mask", {bus.ch_sel, bus.done_mask}, 3'b000);
    step();
    rst = 1'b1;
    step();
    check("post_rst_idle", outs(), 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_channel_scheduler.md
Name: maxpool_channel_scheduler

Overview:
- Time-multiplexes one single-channel max-pool engine across CHANNEL_COUNT feature-map channels.
- On start, walks the enabled channels in ascending order. For each channel it:
  - steers the engine input mux with ch_sel,
  - pulses eng_start,
  - waits for eng_done,
  - pulses cap_en so the pooled result is written into that channel's output buffer.
- Sits between the layer sequencer (start/done) and the pooling datapath. Replaces per-channel engine replication when area is constrained.

Parameters:
- CHANNEL_COUNT, 2, number of channels sharing the engine (>=1).
- CH_W, $clog2(CHANNEL_COUNT) (min 1), width of ch_sel.
- TIMEOUT_CYCLES, 4096, max WAIT cycles per channel before error; 0 disables the timeout.
- TMR_W, 16, timer width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  begin a pass; sampled only in IDLE.
- ch_mask  input  CHANNEL_COUNT  channels to process; latched on accepted start.
- abort  input  1  cancel the pass in progress.
- eng_start  output  1  one-cycle launch pulse to the engine.
- eng_done  input  1  engine completion (pulse or level); sampled only in WAIT.
- ch_sel  output  CH_W  channel index for the engine input/output mux.
- cap_en  output  1  one-cycle write strobe for the result of channel ch_sel.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a pass.
- error  output  1  sticky timeout flag; cleared on the next accepted start.
- done_mask  output  CHANNEL_COUNT  bit i set when channel i has been captured in the current pass.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, timer=0, mask_q=0. All outputs 0: eng_start, ch_sel, cap_en, busy, done, error, done_mask.
- All outputs are decoded from registered state or registered flags; there is no combinational path from inputs to outputs.
- FSM states:
  - IDLE: busy=0.
    - start=1 latches mask_q=ch_mask, clears done_mask and error, sets idx=0, goes to SCAN.
  - SCAN (one cycle per index):
    - If mask_q[idx]=1, go to LAUNCH.
    - Else if idx=CHANNEL_COUNT-1, go to FINISH.
    - Else idx++ and stay in SCAN.
  - LAUNCH: eng_start=1 for exactly one cycle; timer=0; go to WAIT.
  - WAIT: timer++ each cycle.
    - eng_done=1 goes to CAPTURE.
    - Otherwise, if TIMEOUT_CYCLES!=0 and this is the TIMEOUT_CYCLES-th WAIT cycle, set error=1 and go to FINISH; remaining channels are skipped.
  - CAPTURE: cap_en=1 for one cycle; done_mask[idx] is set at the end of the cycle.
    - If idx=CHANNEL_COUNT-1, go to FINISH; else idx++ and go to SCAN.
  - FINISH: done=1 for one cycle; go to IDLE.
- ch_sel=idx in every state; it is stable from LAUNCH through CAPTURE.
- Per-channel overhead: SCAN(1) + LAUNCH(1) + CAPTURE(1) plus engine latency. FINISH adds 1 per pass.
- Boundary conditions:
  - start while busy: ignored.
  - ch_mask changes mid-pass: no effect; mask_q is used.
  - ch_mask=0: SCAN walks all indices, then FINISH. done fires CHANNEL_COUNT+1 cycles after start, with done_mask=0.
  - eng_done and timeout in the same cycle: eng_done wins; no error.
  - eng_done outside WAIT: ignored.
  - abort=1 in any non-IDLE state: next state is IDLE. No done pulse, no further eng_start or cap_en. done_mask keeps partial progress; error is unchanged. abort has priority over every other transition.
  - abort in IDLE: no effect. abort and start both high in IDLE: start is accepted.
  - Reset mid-pass: returns to the reset values immediately.

Test Plan:
- CHANNEL_COUNT=2, mask=11, engine raises eng_done 5 cycles after each eng_start (start at T0):
  - eng_start at T2 and T10, cap_en at T8 and T16 (ch_sel 0 then 1), done at T17.
  - done_mask=11, error=0, busy high T1–T17.
- mask=10:
  - SCAN skips ch0 (T1); eng_start at T3 with ch_sel=1.
  - cap_en exactly once; done_mask=10.
- TIMEOUT_CYCLES=8, mask=01, eng_done never asserted:
  - eng_start at T2, WAIT T3–T10, done at T11 with error=1, done_mask=00.
  - The next start clears error.
- mask=11, abort asserted in the WAIT of ch1:
  - Back in IDLE next cycle; done never pulses; done_mask=01.
  - A subsequent start runs a full pass normally.
- start held high for 20 cycles plus a spurious eng_done in IDLE:
  - Only one pass executes; the spurious eng_done causes no state change.
  - rst pulsed low mid-WAIT forces all outputs to 0 asynchronously.
